// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry
// main_q always holds the head payload; skid_q holds the second entry only in TWO.

module pipe_stage_reg #(
    parameter int unsigned          DATA_W    = 64,
    parameter logic [DATA_W-1:0]    FLUSH_VAL = '0,
    parameter int unsigned          SKID      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic                in_fire;
    logic                out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    // With the skid entry, ready comes straight from a flop so no combinational path crosses the stage.
    assign in_ready = (SKID != 0) ? in_ready_q : ((state_q == EMPTY) | out_ready);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        if (SKID != 0) begin
                            state_d = TWO;
                            skid_d  = in_data;
                        end else begin
                            main_d = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = FLUSH_VAL;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = FLUSH_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_VAL;
                    skid_d  = FLUSH_VAL;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer.
- It replaces the fixed PC/instruction stage latch between pipeline stages. PC and instruction, or any stage bundle, are concatenated into one payload.
- Stall is expressed as downstream out_ready=0; the stage holds its data, and back-pressure propagates upstream without a combinational ready path (SKID=1).

Parameters:
- DATA_W, 64, payload width in bits (e.g. {PC, ins}).
- FLUSH_VAL, 0, payload value after reset or flush, and driven whenever out_valid=0 (bubble/NOP encoding).
- SKID, 1. 1 = two-entry skid buffer with in_ready driven directly from a register. 0 = single entry, in_ready = ~full | out_ready (combinational).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous flush; discards all held entries.
- in_valid, input, 1, upstream has data.
- in_ready, output, 1, stage can accept data.
- in_data, input, DATA_W, upstream payload.
- out_valid, output, 1, stage holds valid data.
- out_ready, input, 1, downstream accepts data (0 = stall).
- out_data, output, DATA_W, head payload.
- occupancy, output, 2, number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - state EMPTY; main and skid registers = FLUSH_VAL.
  - out_valid=0, out_data=FLUSH_VAL, in_ready=1, occupancy=0.
  - No transfer completes on a clock edge during which rst=0.
- States: EMPTY (occ 0), ONE (occ 1, data in main), TWO (occ 2, main = older entry, skid = newer entry; SKID=1 only).
- Outputs per state:
  - out_valid = (state != EMPTY).
  - out_data = main; main equals FLUSH_VAL whenever the state is EMPTY.
  - SKID=1: in_ready = (state != TWO), from a register only.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire only -> TWO, skid <= in_data. out_fire only -> EMPTY, main <= FLUSH_VAL. Neither -> hold.
  - TWO: out_fire -> ONE, main <= skid, skid <= FLUSH_VAL. Otherwise hold. in_fire cannot occur because in_ready=0.
- SKID=0 variant:
  - States EMPTY/ONE only; in_ready = (state==EMPTY) | out_ready.
  - ONE with in_fire & out_fire -> ONE with new data (pass-through every cycle at full throughput).
- Latency and throughput: one cycle from in_fire to out_valid. Sustained throughput is 1 transfer/cycle when out_ready=1 for both SKID values. Payload order is strictly FIFO.
- Flush (flush=1 at an edge):
  - Overrides all transitions: next state EMPTY; main and skid <= FLUSH_VAL.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle counts as delivered (downstream sampled out_data).
  - Flush while already EMPTY has no visible effect.
- Stall: with out_ready=0, out_data and out_valid are held stable until out_fire. Payload never changes under a pending valid.
- Simultaneous flush and reset: reset wins (asynchronous).

Test Plan:
- Reset: rst=0 mid-stream with occ=2 -> immediately out_valid=0, out_data=FLUSH_VAL, in_ready=1, occupancy=0. After release, the first in_data=0x0000_0040_0000_0013 appears on out_data one cycle later.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with payloads 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, no bubbles. Check for both SKID=1 and SKID=0.
- Stall/skid (SKID=1): stream 1,2,3 and drop out_ready after 1 is visible -> occ reaches 2, in_ready=0, payload 3 is held upstream. Raise out_ready -> outputs 1,2,3 in order, nothing lost or duplicated.
- Flush: occ=2 holding A,B, assert flush with in_valid=1, payload C -> next cycle out_valid=0, out_data=FLUSH_VAL, occupancy=0. C is never output.
- Flush with out_fire: occ=1 holding A, out_ready=1 and flush=1 in the same cycle -> A is counted delivered once; the stage is empty afterwards.
- Parameter sweep: DATA_W=32, FLUSH_VAL=0x00000013 -> bubbles and reset output 0x00000013. Random valid/ready/flush traffic against a scoreboard model shows no ordering or loss errors.
